matrix_mac_engine: RTL and testbench

MATRIX_MAC_ENGINE -- requirements
Module: matrix_mac_engine

---
 rtl/matmul_pkg.sv | 38 +++
 rtl/mac_unit.sv | 34 +++
 rtl/matrix_mac_engine.sv | 170 +++++++++++++++++
 tb/tb_matrix_mac_engine.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix multiply-accumulate engine:
// FSM state encoding, dimension limit, address packing and result clamping.
package matmul_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_FLUSH,
      ST_WRITE,
      ST_FIN
   } state_t;

   function automatic int max_dim(input int dim_w);
      return 1 << dim_w;
   endfunction

   // Row-major packing with a fixed row pitch of 2**dim_w elements.
   function automatic logic [31:0] pack_addr(input logic [31:0] row,
                                             input logic [31:0] col,
                                             input int dim_w);
      return (row << dim_w) | col;
   endfunction

   // Clamp a wide signed value to data_w bits, or just keep its low bits.
   function automatic logic [63:0] sat_or_trunc(input logic signed [127:0] v,
                                                input int data_w,
                                                input logic sat);
      logic signed [127:0] hi;
      logic signed [127:0] lo;
      hi = (128'sd1 <<< (data_w - 1)) - 128'sd1;
      lo = -hi - 128'sd1;
      if (sat && (v > hi)) return hi[63:0];
      if (sat && (v < lo)) return lo[63:0];
      return v[63:0];
   endfunction

endpackage

// File: rtl/mac_unit.sv
// Signed multiply-accumulate with synchronous clear and a saturating or
// truncating DATA_W-bit view of the accumulator.
module mac_unit
   import matmul_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 72
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic                     acc_en,
   input  logic                     sat_en,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   output logic [DATA_W-1:0]        result
);

   logic signed [ACC_W-1:0]    acc_q;
   logic signed [2*DATA_W-1:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         acc_q <= '0;
      end else if (acc_en) begin
         acc_q <= acc_q + ACC_W'(prod);
      end
   end

   assign result = DATA_W'(sat_or_trunc(128'(acc_q), DATA_W, sat_en));

endmodule

// File: rtl/matrix_mac_engine.sv
// Computes C = A x B one element at a time, reading A/B through one-cycle
// latency ports and writing each finished C element once.
//
// state | meaning
// IDLE  | waiting for start; dims/sat_en captured on start
// LOAD  | validate dims, clear indices and accumulator
// ISSUE | read A[i][k], B[k][j]; k advances each cycle
// FLUSH | accumulate the last returning product
// WRITE | write C[i][j], step j/i
// FIN   | done pulse (with error when dims were rejected)
module matrix_mac_engine
   import matmul_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ACC_W  = 72,
   parameter int DIM_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [DIM_W:0]      dim_m,
   input  logic [DIM_W:0]      dim_k,
   input  logic [DIM_W:0]      dim_n,
   input  logic                sat_en,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic                a_rd_en,
   output logic [2*DIM_W-1:0]  a_rd_addr,
   input  logic [DATA_W-1:0]   a_rd_data,
   output logic                b_rd_en,
   output logic [2*DIM_W-1:0]  b_rd_addr,
   input  logic [DATA_W-1:0]   b_rd_data,
   output logic                c_wr_en,
   output logic [2*DIM_W-1:0]  c_wr_addr,
   output logic [DATA_W-1:0]   c_wr_data
);

   localparam int             MAX_DIM   = max_dim(DIM_W);
   localparam logic [DIM_W:0] MAX_DIM_V = (DIM_W+1)'(MAX_DIM);
   localparam logic [DIM_W:0] ONE_D     = (DIM_W+1)'(1);
   localparam logic [DIM_W-1:0] ONE_I   = DIM_W'(1);

   state_t state_q, state_d;

   logic [DIM_W:0]   dim_m_q, dim_k_q, dim_n_q;
   logic             sat_q, err_q, issue_q;
   logic [DIM_W-1:0] i_q, j_q, k_q;
   logic             dims_bad, last_i, last_j, last_k;
   logic             mac_clear;
   logic [DATA_W-1:0] mac_result;

   assign dims_bad = (dim_m_q == '0) || (dim_k_q == '0) || (dim_n_q == '0) ||
                     (dim_m_q > MAX_DIM_V) || (dim_k_q > MAX_DIM_V) ||
                     (dim_n_q > MAX_DIM_V);
   assign last_i = ({1'b0, i_q} == (dim_m_q - ONE_D));
   assign last_j = ({1'b0, j_q} == (dim_n_q - ONE_D));
   assign last_k = ({1'b0, k_q} == (dim_k_q - ONE_D));

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      busy      = 1'b0;
      done      = 1'b0;
      error     = 1'b0;
      a_rd_en   = 1'b0;
      b_rd_en   = 1'b0;
      c_wr_en   = 1'b0;
      a_rd_addr = '0;
      b_rd_addr = '0;
      c_wr_addr = '0;
      c_wr_data = '0;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_LOAD;
         ST_LOAD: begin
            busy    = 1'b1;
            state_d = dims_bad ? ST_FIN : ST_ISSUE;
         end
         ST_ISSUE: begin
            busy      = 1'b1;
            a_rd_en   = 1'b1;
            b_rd_en   = 1'b1;
            a_rd_addr = (2*DIM_W)'(pack_addr(32'(i_q), 32'(k_q), DIM_W));
            b_rd_addr = (2*DIM_W)'(pack_addr(32'(k_q), 32'(j_q), DIM_W));
            if (last_k) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            busy    = 1'b1;
            state_d = ST_WRITE;
         end
         ST_WRITE: begin
            busy      = 1'b1;
            c_wr_en   = 1'b1;
            c_wr_addr = (2*DIM_W)'(pack_addr(32'(i_q), 32'(j_q), DIM_W));
            c_wr_data = mac_result;
            state_d   = (last_i && last_j) ? ST_FIN : ST_ISSUE;
         end
         ST_FIN: begin
            done    = 1'b1;
            error   = err_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dim_m_q <= '0;
         dim_k_q <= '0;
         dim_n_q <= '0;
         sat_q   <= 1'b0;
         err_q   <= 1'b0;
         issue_q <= 1'b0;
         i_q     <= '0;
         j_q     <= '0;
         k_q     <= '0;
      end else begin
         issue_q <= (state_q == ST_ISSUE);
         unique case (state_q)
            ST_IDLE: if (start) begin
               dim_m_q <= dim_m;
               dim_k_q <= dim_k;
               dim_n_q <= dim_n;
               sat_q   <= sat_en;
               err_q   <= 1'b0;
            end
            ST_LOAD: begin
               err_q <= dims_bad;
               i_q   <= '0;
               j_q   <= '0;
               k_q   <= '0;
            end
            ST_ISSUE: k_q <= k_q + ONE_I;
            ST_WRITE: begin
               k_q <= '0;
               if (last_j) begin
                  j_q <= '0;
                  i_q <= i_q + ONE_I;
               end else begin
                  j_q <= j_q + ONE_I;
               end
            end
            default: ;
         endcase
      end
   end

   // Products land one cycle after their issue, so accumulation trails ISSUE.
   assign mac_clear = (state_q == ST_LOAD) || (state_q == ST_WRITE);

   mac_unit #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clear  (mac_clear),
      .acc_en (issue_q),
      .sat_en (sat_q),
      .a      (a_rd_data),
      .b      (b_rd_data),
      .result (mac_result)
   );

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Scoreboard bench for matrix_mac_engine: stimulus queues expected C writes
// and done pulses; a negedge monitor pops and compares them.
module tb_matrix_mac_engine;

   logic        clk = 1'b0;
   logic        reset, start, sat_en;
   logic [4:0]  dim_m, dim_k, dim_n;
   logic        busy, done, error;
   logic        a_rd_en, b_rd_en, c_wr_en;
   logic [7:0]  a_rd_addr, b_rd_addr, c_wr_addr;
   logic [31:0] a_rd_data, b_rd_data, c_wr_data;

   typedef struct { logic [7:0] addr; logic [31:0] data; } wr_t;
   typedef struct { int cyc; logic err; } dn_t;

   wr_t exp_wr[$];
   dn_t exp_dn[$];

   logic signed [31:0] mem_a [256];
   logic signed [31:0] mem_b [256];

   int checks = 0, failures = 0;
   int cyc = 0, start_cyc = 0;
   int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      if (a_rd_en) a_rd_data <= mem_a[a_rd_addr];
      if (b_rd_en) b_rd_data <= mem_b[b_rd_addr];
   end

   matrix_mac_engine dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .dim_m     (dim_m),
      .dim_k     (dim_k),
      .dim_n     (dim_n),
      .sat_en    (sat_en),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .a_rd_en   (a_rd_en),
      .a_rd_addr (a_rd_addr),
      .a_rd_data (a_rd_data),
      .b_rd_en   (b_rd_en),
      .b_rd_addr (b_rd_addr),
      .b_rd_data (b_rd_data),
      .c_wr_en   (c_wr_en),
      .c_wr_addr (c_wr_addr),
      .c_wr_data (c_wr_data)
   );

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   wr_t got_wr;
   dn_t got_dn;
   always @(negedge clk) begin
      if (!reset) begin
         if (a_rd_en || b_rd_en) rd_cnt++;
         if (c_wr_en) begin
            wr_cnt++;
            if (exp_wr.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write addr=%0d data=%h", c_wr_addr, c_wr_data);
            end else begin
               got_wr = exp_wr.pop_front();
               chk("wr_addr", c_wr_addr, got_wr.addr);
               chk("wr_data", c_wr_data, got_wr.data);
            end
         end
         if (done) begin
            done_cnt++;
            if (exp_dn.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_done cycle=%0d", cyc);
            end else begin
               got_dn = exp_dn.pop_front();
               chk("done_cycle", cyc, got_dn.cyc);
               chk("done_error", error, got_dn.err);
               chk("busy_at_done", busy, 1'b0);
            end
         end
      end
   end

   function automatic logic [31:0] model_c(input int i, input int j, input int kd, input bit sat);
      logic signed [71:0] s;
      s = '0;
      for (int kk = 0; kk < kd; kk++)
         s = s + 72'(mem_a[i*16+kk]) * 72'(mem_b[kk*16+j]);
      if (sat && s > 72'sd2147483647) return 32'h7FFF_FFFF;
      if (sat && s < -72'sd2147483648) return 32'h8000_0000;
      return s[31:0];
   endfunction

   task automatic clear_mem();
      for (int x = 0; x < 256; x++) begin
         mem_a[x] = '0;
         mem_b[x] = '0;
      end
   endtask

   task automatic push_wr(input int addr, input logic [31:0] data);
      wr_t e;
      e.addr = 8'(addr);
      e.data = data;
      exp_wr.push_back(e);
   endtask

   task automatic push_dn(input int rel, input logic err);
      dn_t e;
      e.cyc = start_cyc + rel;
      e.err = err;
      exp_dn.push_back(e);
   endtask

   task automatic push_model(input int m, input int k, input int n, input bit sat);
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++)
            push_wr(i*16 + j, model_c(i, j, k, sat));
      push_dn(m*n*(k+2) + 2, 1'b0);
   endtask

   // Returns at the start of the cycle after start was sampled (LOAD).
   task automatic pulse_start(input int m, input int k, input int n, input bit sat);
      @(posedge clk); #1;
      dim_m = 5'(m); dim_k = 5'(k); dim_n = 5'(n); sat_en = sat;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      dim_m = '0; dim_k = '0; dim_n = '0; sat_en = ~sat;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!done && n < budget);
      if (!done) chk({nm, "_timeout"}, 0, 1);
   endtask

   initial begin
      int rd0, wr0, dn0;
      reset = 1'b1; start = 1'b0; sat_en = 1'b0;
      dim_m = '0; dim_k = '0; dim_n = '0;
      a_rd_data = '0; b_rd_data = '0;
      clear_mem();
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_outputs", {busy, done, error, a_rd_en, b_rd_en, c_wr_en,
                            a_rd_addr, b_rd_addr, c_wr_addr, c_wr_data}, '0);

      // Test 1: 2x2x2, B identity
      clear_mem();
      mem_a[0] = 1; mem_a[1] = 2; mem_a[16] = 3; mem_a[17] = 4;
      mem_b[0] = 1; mem_b[17] = 1;
      pulse_start(2, 2, 2, 1'b1);
      chk("t1_busy_load", busy, 1'b1);
      push_wr(0, 32'd1); push_wr(1, 32'd2); push_wr(16, 32'd3); push_wr(17, 32'd4);
      push_dn(18, 1'b0);
      wait_done("t1", 40);

      // Test 2: saturation and truncation
      clear_mem();
      mem_a[0] = 32'sh7FFF_FFFF; mem_a[1] = 32'sh7FFF_FFFF;
      mem_b[0] = 2; mem_b[16] = 2;
      pulse_start(1, 2, 1, 1'b1);
      push_wr(0, 32'h7FFF_FFFF); push_dn(6, 1'b0);
      wait_done("t2_sat", 20);
      pulse_start(1, 2, 1, 1'b0);
      push_wr(0, 32'hFFFF_FFFC); push_dn(6, 1'b0);
      wait_done("t2_trunc", 20);

      // Test 3: rejected dims
      rd0 = rd_cnt; wr0 = wr_cnt;
      pulse_start(2, 0, 2, 1'b0);
      chk("t3_busy_load", busy, 1'b1);
      push_dn(2, 1'b1);
      wait_done("t3_k0", 10);
      pulse_start(17, 2, 2, 1'b0);
      push_dn(2, 1'b1);
      wait_done("t3_m17", 10);
      chk("t3_no_reads", rd_cnt - rd0, 0);
      chk("t3_no_writes", wr_cnt - wr0, 0);

      // Test 4: reset mid-job at cycle 10, then a clean job
      clear_mem();
      for (int x = 0; x < 3; x++)
         for (int y = 0; y < 3; y++) begin
            mem_a[x*16+y] = 32'(x*3 + y + 1);
            mem_b[x*16+y] = 32'(y - x);
         end
      pulse_start(3, 3, 3, 1'b1);
      push_wr(0, model_c(0, 0, 3, 1'b1));
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      wr0 = wr_cnt; dn0 = done_cnt;
      @(negedge clk);
      chk("t4_outputs_after_reset", {busy, done, a_rd_en, c_wr_en, a_rd_addr, c_wr_data}, '0);
      repeat (20) @(negedge clk);
      chk("t4_no_write_after_reset", wr_cnt - wr0, 0);
      chk("t4_no_done_after_reset", done_cnt - dn0, 0);
      chk("t4_busy_low", busy, 1'b0);
      pulse_start(3, 3, 3, 1'b1);
      push_model(3, 3, 3, 1'b1);
      wait_done("t4_rerun", 60);

      // Reset and start in the same cycle: start must be dropped
      @(posedge clk); #1;
      reset = 1'b1; start = 1'b1; dim_m = 5'd2; dim_k = 5'd2; dim_n = 5'd2;
      @(posedge clk); #1;
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("reset_beats_start", busy, 1'b0);

      // Test 5: second start while busy is ignored
      clear_mem();
      mem_a[0] = -5; mem_a[1] = 7; mem_a[16] = 11; mem_a[17] = -13;
      mem_b[0] = 2; mem_b[1] = -3; mem_b[16] = 4; mem_b[17] = 6;
      pulse_start(2, 2, 2, 1'b0);
      // [-5 7; 11 -13] x [2 -3; 4 6] = [18 57; -30 -111]
      push_wr(0, 32'd18); push_wr(1, 32'd57);
      push_wr(16, -32'sd30); push_wr(17, -32'sd111);
      push_dn(18, 1'b0);
      repeat (3) @(posedge clk);
      #1 start = 1'b1; dim_m = 5'd3; dim_k = 5'd3; dim_n = 5'd3; sat_en = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done("t5", 40);
      repeat (3) @(negedge clk);
      chk("t5_idle_after", busy, 1'b0);

      // Test 6: full 16x16x16 signed random job
      for (int x = 0; x < 256; x++) begin
         mem_a[x] = $signed($urandom) >>> $urandom_range(0, 14);
         mem_b[x] = $signed($urandom) >>> $urandom_range(0, 14);
      end
      wr0 = wr_cnt;
      pulse_start(16, 16, 16, 1'b1);
      push_model(16, 16, 16, 1'b1);
      wait_done("t6", 5000);
      chk("t6_write_count", wr_cnt - wr0, 256);

      repeat (3) @(negedge clk);
      chk("wr_queue_drained", exp_wr.size(), 0);
      chk("done_queue_drained", exp_dn.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
